// File: rtl/if_fetch_unit.sv
// IF stage: req/ack instruction fetch feeding the IF/ID register.
// Optional perf counters are enabled by IF_FETCH_PERF_EN.
module if_fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PCF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0] FetchCount,
    output logic [31:0] WaitCycles,
`endif
    output logic        FetchBusy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_KILL,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        load;
    logic [31:0] ld_instr;
    logic [31:0] ld_pc;
    logic        in_flight;

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        load         = 1'b0;
        ld_instr     = IMemRData;
        ld_pc        = req_addr_q;
        IMemReq      = 1'b0;
        IMemAddr     = req_addr_q;
        FetchBusy    = 1'b0;
        in_flight    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                FetchBusy = 1'b1;
                state_d   = S_REQ;
            end
            S_REQ, S_WAIT: begin
                IMemReq   = 1'b1;
                in_flight = 1'b1;
                if (state_q == S_REQ) begin
                    IMemAddr   = PCF;
                    req_addr_d = PCF;
                end
                FetchBusy = !IMemAck && !FlushD;
                ld_pc     = IMemAddr;
                if (FlushD) begin
                    state_d = IMemAck ? S_REQ : S_KILL;
                end else if (IMemAck) begin
                    if (StallD) begin
                        skid_instr_d = IMemRData;
                        skid_pc_d    = IMemAddr;
                        state_d      = S_HOLD;
                    end else begin
                        load    = 1'b1;
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_KILL: begin
                IMemReq   = 1'b1;
                FetchBusy = 1'b1;
                in_flight = 1'b1;
                if (IMemAck) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                ld_instr = skid_instr_q;
                ld_pc    = skid_pc_q;
                if (FlushD) begin
                    state_d = S_REQ;
                end else if (!StallD) begin
                    load    = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Flush always wins, then a capture, then bubble-or-hold on StallD.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (FlushD || (!load && !StallD)) begin
            instr_d = NOP_INSTR;
            pc_d    = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = ld_instr;
            pc_d    = ld_pc;
            pc4_d   = ld_pc + 32'd4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            req_addr_q   <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            instr_q      <= NOP_INSTR;
            pc_q         <= 32'h0;
            pc4_q        <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pc_q;
    assign PCPlus4D = pc4_q;
    assign ValidD   = valid_q;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        fetched;

    assign fetched = load && !FlushD;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (fetched && fetch_cnt_q != 32'hFFFF_FFFF) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (in_flight && FetchBusy
            && wait_cnt_q != 32'hFFFF_FFFF) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetch_cnt_q <= 32'h0;
            wait_cnt_q  <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign WaitCycles = wait_cnt_q;
`else
    logic unused_in_flight;
    assign unused_in_flight = in_flight;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic
// checked against a transaction-level fetch model.
module tb_if_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] PCF = 32'h0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemRData = 32'h0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        FetchBusy;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] WaitCycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    if_fetch_unit #(.NOP_INSTR(32'h0000_0000)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PCF       (PCF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemAck   (IMemAck),
        .IMemRData (IMemRData),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
`ifdef IF_FETCH_PERF_EN
        .FetchCount(FetchCount),
        .WaitCycles(WaitCycles),
`endif
        .FetchBusy (FetchBusy)
    );

    // Reference model: a fetch is either not started, parked in a
    // one-entry skid queue, orphaned (killed), or outstanding.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        skid[$];
    bit          m_started;
    bit          m_pending;
    bit          m_killed;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;
    longint      m_fetch;
    longint      m_wait;
    logic        last_busy;

    task automatic model_reset();
        skid.delete();
        m_started = 0;
        m_pending = 0;
        m_killed  = 0;
        m_addr    = 32'h0;
        m_instr   = 32'h0;
        m_pc      = 32'h0;
        m_valid   = 1'b0;
        m_fetch   = 0;
        m_wait    = 0;
    endtask

    function automatic bit model_req();
        return m_started && skid.size() == 0;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] pcf,
                        input logic stall,
                        input logic flush,
                        input logic ack,
                        input logic [31:0] data);
        logic        e_req, e_busy, counts, deliver;
        logic [31:0] e_addr;
        ent_t        d;
        @(negedge CLK);
        PCF = pcf;
        StallD = stall;
        FlushD = flush;
        IMemAck = ack;
        IMemRData = data;
        e_addr = 32'h0;
        counts = 1'b0;
        deliver = 1'b0;
        d.instr = 32'h0;
        d.pc = 32'h0;
        if (!m_started) begin
            e_req = 1'b0;
            e_busy = 1'b1;
        end else if (skid.size() != 0) begin
            e_req = 1'b0;
            e_busy = 1'b0;
        end else if (m_killed) begin
            e_req = 1'b1;
            e_addr = m_addr;
            e_busy = 1'b1;
            counts = 1'b1;
        end else begin
            e_req = 1'b1;
            e_addr = m_pending ? m_addr : pcf;
            e_busy = !ack && !flush;
            counts = e_busy;
        end
        #1;
        chk("req", {31'h0, IMemReq}, {31'h0, e_req});
        chk("busy", {31'h0, FetchBusy}, {31'h0, e_busy});
        if (e_req) chk("addr", IMemAddr, e_addr);
        last_busy = e_busy;
        @(posedge CLK);
        if (counts) m_wait++;
        if (!m_started) begin
            m_started = 1;
        end else if (skid.size() != 0) begin
            if (flush) skid.delete();
            else if (!stall) begin
                d = skid.pop_front();
                deliver = 1'b1;
            end
        end else if (m_killed) begin
            if (ack) m_killed = 0;
        end else if (flush) begin
            m_pending = 0;
            if (!ack) begin
                m_killed = 1;
                m_addr = e_addr;
            end
        end else if (ack) begin
            m_pending = 0;
            d.instr = data;
            d.pc = e_addr;
            if (stall) skid.push_back(d);
            else deliver = 1'b1;
        end else begin
            m_pending = 1;
            m_addr = e_addr;
        end
        if (flush || (!deliver && !stall)) begin
            m_instr = 32'h0;
            m_pc = 32'h0;
            m_valid = 1'b0;
        end else if (deliver) begin
            m_instr = d.instr;
            m_pc = d.pc;
            m_valid = 1'b1;
            m_fetch++;
        end
        #1;
        chk("instr", InstrD, m_instr);
        chk("pcd", PCD, m_pc);
        chk("pc4", PCPlus4D, m_valid ? m_pc + 32'd4 : 32'h0);
        chk("valid", {31'h0, ValidD}, {31'h0, m_valid});
`ifdef IF_FETCH_PERF_EN
        chk("fcnt", FetchCount, m_fetch > 64'hFFFF_FFFF ?
            32'hFFFF_FFFF : m_fetch[31:0]);
        chk("wcnt", WaitCycles, m_wait > 64'hFFFF_FFFF ?
            32'hFFFF_FFFF : m_wait[31:0]);
`endif
    endtask

    initial begin
        logic [31:0] pc;
        logic        st, fl, ak;
        model_reset();
        last_busy = 1'b1;
        #3;
        chk("rst_instr", InstrD, 32'h0);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pc4", PCPlus4D, 32'h0);
        chk("rst_valid", {31'h0, ValidD}, 32'h0);
        chk("rst_req", {31'h0, IMemReq}, 32'h0);
        @(posedge CLK);
        #2 RST = 1'b1;

        // Back-to-back fetches with single-cycle ack.
        step(32'h0, 0, 0, 0, 32'h0);
        step(32'h0, 0, 0, 1, 32'hA0);
        chk("s1_i0", InstrD, 32'hA0);
        chk("s1_p0", PCD, 32'h0);
        chk("s1_q0", PCPlus4D, 32'h4);
        step(32'h4, 0, 0, 1, 32'hA1);
        chk("s1_p1", PCD, 32'h4);
        chk("s1_q1", PCPlus4D, 32'h8);
        step(32'h8, 0, 0, 1, 32'hA2);
        chk("s1_i2", InstrD, 32'hA2);
        chk("s1_q2", PCPlus4D, 32'hC);
        chk("s1_v2", {31'h0, ValidD}, 32'h1);

        // Ack three cycles late.
        for (int i = 0; i < 3; i++) begin
            step(32'h10, 0, 0, 0, 32'h0);
            chk("s2_addr", IMemAddr, 32'h10);
            chk("s2_bub", {31'h0, ValidD}, 32'h0);
        end
        step(32'h10, 0, 0, 1, 32'hC0DE);
        chk("s2_i", InstrD, 32'hC0DE);
        chk("s2_p", PCD, 32'h10);

        // Flush while waiting; late data must be dropped.
        step(32'h20, 0, 0, 0, 32'h0);
        step(32'h100, 0, 1, 0, 32'h0);
        step(32'h100, 0, 0, 0, 32'h0);
        step(32'h100, 0, 0, 1, 32'hDEAD);
        chk("s3_drop", {31'h0, InstrD == 32'hDEAD}, 32'h0);
        chk("s3_addr", IMemAddr, 32'h100);
        step(32'h100, 0, 0, 1, 32'h55);
        chk("s3_p", PCD, 32'h100);

        // Ack under decode stall goes to the skid buffer.
        step(32'h40, 1, 0, 1, 32'hBEEF);
        chk("s4_hold", InstrD, 32'h55);
        chk("s4_req", {31'h0, IMemReq}, 32'h0);
        step(32'h40, 1, 0, 0, 32'h0);
        chk("s4_hold2", PCD, 32'h100);
        step(32'h40, 0, 0, 0, 32'h0);
        chk("s4_i", InstrD, 32'hBEEF);
        chk("s4_p", PCD, 32'h40);

        // Flush with ack, then flush while holding.
        step(32'h44, 0, 1, 1, 32'h1234);
        chk("s5_i", InstrD, 32'h0);
        chk("s5_v", {31'h0, ValidD}, 32'h0);
        step(32'h48, 1, 0, 1, 32'h77);
        step(32'h48, 1, 1, 0, 32'h0);
        chk("s5_v2", {31'h0, ValidD}, 32'h0);
        chk("s5_req", {31'h0, IMemReq}, 32'h1);

        // PC+4 wraps.
        step(32'hFFFF_FFFC, 0, 0, 1, 32'h99);
        chk("s6_q", PCPlus4D, 32'h0);

        // Async reset in the middle of a request.
        step(32'h200, 0, 0, 0, 32'h0);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("ar_req", {31'h0, IMemReq}, 32'h0);
        chk("ar_valid", {31'h0, ValidD}, 32'h0);
        model_reset();
        IMemAck = 1'b1;
        IMemRData = 32'hBAD;
        @(posedge CLK);
        #2 RST = 1'b1;
        step(32'h0, 0, 0, 1, 32'hBAD);
        step(32'h0, 0, 0, 0, 32'h0);
        chk("ar_late", {31'h0, ValidD}, 32'h0);

        // Random traffic; the bench plays PC register and memory.
        pc = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 15) == 0);
            ak = model_req() && ($urandom_range(0, 2) == 0);
            step(pc, st, fl, ak, $urandom);
            if (fl) pc = $urandom;
            else if (!last_busy && !st) pc = pc + 32'd4;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register; consumes PCF.
- Issues word requests to a variable-latency instruction memory using a req/ack handshake.
- Delivers the IF/ID pipeline register contents: InstrD, PCD, PCPlus4D, ValidD.
- Drives FetchBusy to the hazard unit, which ORs it into StallF; handles decode stall, flush/redirect and in-flight kill.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word driven on InstrD for bubbles, flushes and reset.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- PCF  in  32  current fetch PC from the PC register.
- StallD  in  1  hold the IF/ID outputs.
- FlushD  in  1  redirect/flush; priority over StallD.
- IMemReq  out  1  request valid; held high until ack.
- IMemAddr  out  32  request address; stable while IMemReq is high.
- IMemAck  in  1  one-cycle pulse; IMemRData valid in the same cycle.
- IMemRData  in  32  instruction word.
- InstrD  out  32  decode-stage instruction.
- PCD  out  32  decode-stage PC.
- PCPlus4D  out  32  PCD+4.
- ValidD  out  1  InstrD holds a real instruction.
- FetchBusy  out  1  PC must hold.

Behaviour:
- Reset values: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, state=IDLE, ReqAddr=0, skid buffer empty.
- Async reset mid-request abandons the transaction. IMemReq drops immediately; a late IMemAck is ignored.
- States:
  - IDLE: IMemReq=0, FetchBusy=1. Always goes to REQ next cycle.
  - REQ: IMemReq=1, IMemAddr=PCF, ReqAddr<=PCF.
  - WAIT: IMemReq=1, IMemAddr=ReqAddr.
  - KILL: IMemReq=1, IMemAddr=ReqAddr, FetchBusy=1. On IMemAck, data is discarded and the state goes to REQ.
  - HOLD: IMemReq=0, FetchBusy=0. The skid buffer is full.
- FetchBusy in REQ/WAIT = !IMemAck & !FlushD.
- In REQ/WAIT, priority is FlushD > IMemAck > none:
  - FlushD & IMemAck: discard data; go to REQ.
  - FlushD & !IMemAck: go to KILL.
  - IMemAck & !StallD: IF/ID loads {IMemRData, address, address+4}, ValidD<=1; go to REQ.
  - IMemAck & StallD: skid buffer <= {IMemRData, address}; IF/ID holds; go to HOLD.
  - No ack: REQ goes to WAIT; WAIT stays in WAIT.
- IF/ID update in REQ/WAIT/KILL/IDLE when there is no capture:
  - !StallD: bubble (InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0).
  - StallD: hold.
- HOLD:
  - FlushD: drop the skid buffer, IF/ID bubble, go to REQ.
  - !StallD: IF/ID loads from the skid buffer, ValidD=1, go to REQ.
  - Otherwise: hold.
- FlushD from any state forces an IF/ID bubble on the same edge.
- Throughput: with single-cycle ack and no stall, one instruction per cycle. Latency from PCF to ValidD is one edge after ack.
- PCPlus4D is computed modulo 2^32, e.g. 0xFFFFFFFC -> 0x00000000.
- IMemAddr bits [1:0] are passed through unchanged; no alignment check.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined, adds two ports: FetchCount out 32 and WaitCycles out 32.
  - FetchCount increments on each edge where IF/ID loads a valid instruction.
  - WaitCycles increments each cycle FetchBusy=1 in REQ/WAIT/KILL.
  - Both saturate at 32'hFFFFFFFF; reset value 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, ack every cycle, PCF stepping 0x0, 0x4, 0x8 with data 0xA0, 0xA1, 0xA2 -> ValidD=1 on consecutive cycles; PCD=0x0/0x4/0x8; PCPlus4D=0x4/0x8/0xC; FetchBusy=0 after IDLE.
- Ack delayed 3 cycles at PCF=0x10 -> IMemAddr stays 0x10; FetchBusy=1 for 3 cycles; then InstrD=data, PCD=0x10, with bubbles during the wait.
- FlushD asserted in WAIT (ReqAddr=0x20); PCF redirects to 0x100; late ack returns 0xDEAD -> 0xDEAD never appears on InstrD; next request address is 0x100.
- Ack with StallD=1 for 2 cycles (data 0xBEEF, PC 0x40) -> IF/ID holds its old value, state is HOLD; after release InstrD=0xBEEF, PCD=0x40.
- FlushD and IMemAck in the same cycle, and FlushD in HOLD -> data is dropped, IF/ID becomes a bubble (InstrD=NOP_INSTR, ValidD=0), and the next state is REQ.
- PCF=0xFFFFFFFC fetched -> PCPlus4D=0x0. With IF_FETCH_PERF_EN defined, counters match the delivered/wait cycle counts of the above scenarios.
